// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, field positions and state encoding for fp_pack_norm
package fp_pkg;
  localparam int EW      = 8;
  localparam int MW      = 24;
  localparam int GW      = 3;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int XW      = EW + 2;
  localparam int MTW     = MW + GW + 1;

  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;

  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] ZERO    = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even on a normalised mantissa with G/R/S tail
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MTW-1:0]        m_i,
  input  logic signed [XW-1:0]  e_i,
  output logic [MTW-1:0]        m_o,
  output logic signed [XW-1:0]  e_o,
  output logic                  carry_o
);
  logic               inc;
  logic [MTW-GW-1:0]  sum;

  assign inc     = m_i[GW-1] & (m_i[GW-2] | m_i[0] | m_i[GW]);
  assign sum     = m_i[MTW-1:GW] + {{(MTW-GW-1){1'b0}}, inc};
  assign carry_o = sum[MTW-GW-1];
  // m_o keeps the unshifted sum; the consumer picks the field one bit higher on carry.
  assign m_o     = {sum, m_i[GW-1:0]};
  assign e_o     = e_i + {{(XW-1){1'b0}}, carry_o};
endmodule

// File: rtl/fp_pack_norm.sv
// rtl/fp_pack_norm.sv - normalise, round and pack a quotient into IEEE-754 single precision
module fp_pack_norm
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_s,
  input  logic [XW-1:0]  in_e,
  input  logic [MTW-1:0] in_m,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    out_f,
  output logic           out_ovf,
  output logic           out_unf
);
  localparam logic signed [XW-1:0] E_MAX  = XW'(EXP_MAX);
  localparam logic signed [XW-1:0] E_ZERO = '0;

  state_t               state_q, state_d;
  logic                 s_q, s_d;
  logic signed [XW-1:0] e_q, e_d;
  logic [MTW-1:0]       m_q, m_d;
  logic [31:0]          f_q, f_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d;

  logic [MTW-1:0]       m_r;
  logic signed [XW-1:0] e_r;
  logic                 carry_r;

  fp_round_rne u_round (
    .m_i     (m_q),
    .e_i     (e_q),
    .m_o     (m_r),
    .e_o     (e_r),
    .carry_o (carry_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      e_q     <= '0;
      m_q     <= '0;
      f_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      e_q     <= e_d;
      m_q     <= m_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    e_d     = e_q;
    m_d     = m_q;
    f_d     = f_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_s;
          e_d     = in_e;
          m_d     = in_m;
          state_d = NORM;
        end
      end
      NORM: begin
        // A zero mantissa passes through ROUND unchanged so every word sees the same minimum latency.
        if (m_q == '0) begin
          state_d = ROUND;
        end else if (m_q[MTW-1]) begin
          m_d     = {1'b0, m_q[MTW-1:2], m_q[1] | m_q[0]};
          e_d     = e_q + XW'(1);
          state_d = ROUND;
        end else if (m_q[MTW-2]) begin
          state_d = ROUND;
        end else begin
          m_d = m_q << 1;
          e_d = e_q - XW'(1);
        end
      end
      ROUND: begin
        state_d = DONE;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (m_r == '0) begin
          f_d = {s_q, ZERO[30:0]};
        end else if (e_r >= E_MAX) begin
          f_d   = s_q ? NEG_INF : POS_INF;
          ovf_d = 1'b1;
        end else if (e_r <= E_ZERO) begin
          f_d   = {s_q, ZERO[30:0]};
          unf_d = 1'b1;
        end else begin
          f_d[SIGN_BIT]      = s_q;
          f_d[EXP_HI:EXP_LO] = e_r[EW-1:0];
          f_d[FRAC_HI:0]     = carry_r ? m_r[MTW-2:GW+1] : m_r[MTW-3:GW];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_f     = f_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;
endmodule

// File: tb/tb_fp_pack_norm.sv
// tb/tb_fp_pack_norm.sv - scoreboard bench for fp_pack_norm with directed vectors
module tb_fp_pack_norm;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_s;
  logic [9:0]  in_e;
  logic [27:0] in_m;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;
  logic        out_ovf;
  logic        out_unf;

  fp_pack_norm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_e      (in_e),
    .in_m      (in_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f;
    logic [1:0]  flags;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   last_acc = 0;
  bit   prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) rise_cyc = cyc;
      prev_v = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", out_f, 32'hxxxx_xxxx);
        end else begin
          x = sb.pop_front();
          check("out_f", out_f, x.f);
          check("flags_ovf_unf", {30'b0, out_ovf, out_unf}, {30'b0, x.flags});
          check("latency", rise_cyc - x.acc, x.lat);
        end
      end
    end
  end

  task automatic send(input logic s, input logic [9:0] e, input logic [27:0] m,
                      input logic [31:0] f, input logic [1:0] flags, input int lat, input bit push);
    int budget = 0;
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    in_s = s;
    in_e = e;
    in_m = m;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last_acc = cyc;
    if (push) begin
      x.f = f; x.flags = flags; x.lat = lat; x.acc = cyc;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    int budget = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0 || out_valid) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc_a;
    int budget;
    bit any_valid;
    rst = 1'b1;
    in_valid = 1'b0;
    in_s = 1'b0;
    in_e = '0;
    in_m = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_f", out_f, 32'd0);
    check("rst_flags", {30'b0, out_ovf, out_unf}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    send(1'b0, 10'd127, 28'h4000000, 32'h3F800000, 2'b00, 2, 1'b1);
    send(1'b0, 10'd127, 28'h8000000, 32'h40000000, 2'b00, 2, 1'b1);
    send(1'b0, 10'd129, 28'h1000000, 32'h3F800000, 2'b00, 4, 1'b1);
    send(1'b0, 10'd127, 28'h4000004, 32'h3F800000, 2'b00, 2, 1'b1);
    send(1'b0, 10'd127, 28'h400000C, 32'h3F800002, 2'b00, 2, 1'b1);
    send(1'b0, 10'd127, 28'h7FFFFFC, 32'h40000000, 2'b00, 2, 1'b1);
    send(1'b0, 10'd255, 28'h4000000, 32'h7F800000, 2'b10, 2, 1'b1);
    drain();
    check("ovf_cleared", 32'(out_ovf), 32'd0);
    send(1'b1, 10'd0, 28'h4000000, 32'h80000000, 2'b01, 2, 1'b1);
    drain();
    check("unf_cleared", 32'(out_unf), 32'd0);
    send(1'b1, 10'd50, 28'h0000000, 32'h80000000, 2'b00, 2, 1'b1);
    drain();

    // Stall downstream for five cycles in DONE.
    out_ready = 1'b0;
    send(1'b0, 10'd127, 28'h4000000, 32'h3F800000, 2'b00, 2, 1'b1);
    budget = 0;
    @(negedge clk);
    while (!out_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_f", out_f, 32'h3F800000);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back: the second word waits with in_valid high until IDLE.
    send(1'b0, 10'd127, 28'h4000000, 32'h3F800000, 2'b00, 2, 1'b1);
    acc_a = last_acc;
    send(1'b1, 10'd128, 28'h4000000, 32'hC0000000, 2'b00, 2, 1'b1);
    check("b2b_gap_ge3", 32'(last_acc - acc_a >= 3), 32'd1);
    drain();

    // Reset during NORM of a k=10 word.
    send(1'b0, 10'd137, 28'h0010000, 32'h3F800000, 2'b00, 12, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_post_in_ready", 32'(in_ready), 32'd1);
    any_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      any_valid |= out_valid;
    end
    check("abort_no_stale", 32'(any_valid), 32'd0);
    send(1'b0, 10'd127, 28'h4000000, 32'h3F800000, 2'b00, 2, 1'b1);
    drain();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
